// File: rtl/matrix_xfer_sequencer.sv
// Job sequencer for one sparse matrix multiply: receives A rows and B columns into
// vector memory, kicks the multiply core, then streams the result rows back out.
module matrix_xfer_sequencer #(
  parameter int MATRIX_N = 4,
  parameter int HEADER   = 1,
  parameter int DW       = HEADER*8 + 32*MATRIX_N,
  parameter int AW       = $clog2(3*MATRIX_N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  output logic          comm_op,
  output logic          comm_start,
  input  logic          comm_rx_complete,
  input  logic          comm_tx_complete,
  input  logic [DW-1:0] comm_rx_data,
  output logic [DW-1:0] comm_tx_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mult_start,
  input  logic          mult_done,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int VW = $clog2(2*MATRIX_N+1);
  localparam int HW = HEADER*8;
  localparam logic [VW-1:0] RX_LAST  = VW'(2*MATRIX_N);
  localparam logic [VW-1:0] TX_LAST  = VW'(MATRIX_N);
  localparam logic [AW-1:0] RES_BASE = AW'(2*MATRIX_N);
  localparam logic [HW-1:0] SIZE_MAX = HW'(MATRIX_N);

  typedef enum logic [3:0] {
    IDLE, RX_START, RX_WAIT, RX_STORE, MULT_START, MULT_WAIT,
    TX_READ, TX_LATCH, TX_START, TX_WAIT, DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [VW-1:0]   r_vidx;
  logic [VW-1:0]   w_vidx_inc;
  logic [DW-1:0]   r_rx_buf;
  logic [DW-1:0]   r_tx_data;
  logic            r_error;
  logic [HW-1:0]   w_size_of;
  logic            w_hdr_bad;

  assign w_vidx_inc = r_vidx + VW'(1);
  assign w_size_of  = comm_rx_data[DW-1 -: HW];
  assign w_hdr_bad  = (w_size_of == '0) || (w_size_of > SIZE_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Each wait state reacts only to its own completion event; everything else is ignored.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:       if (go) w_state_next = RX_START;
      RX_START:   w_state_next = RX_WAIT;
      RX_WAIT:    if (comm_rx_complete) w_state_next = RX_STORE;
      RX_STORE:   w_state_next = (w_vidx_inc == RX_LAST) ? MULT_START : RX_START;
      MULT_START: w_state_next = MULT_WAIT;
      MULT_WAIT:  if (mult_done) w_state_next = TX_READ;
      TX_READ:    w_state_next = TX_LATCH;
      TX_LATCH:   w_state_next = TX_START;
      TX_START:   w_state_next = TX_WAIT;
      TX_WAIT: begin
        if (comm_tx_complete) begin
          w_state_next = (w_vidx_inc == TX_LAST) ? DONE : TX_READ;
        end
      end
      DONE:       w_state_next = IDLE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vidx    <= '0;
      r_rx_buf  <= '0;
      r_tx_data <= '0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_vidx <= '0;
          if (go) r_error <= 1'b0;
        end
        RX_WAIT: begin
          if (comm_rx_complete) begin
            r_rx_buf <= comm_rx_data;
            // A bad header is flagged but the vector is still stored.
            if (w_hdr_bad) r_error <= 1'b1;
          end
        end
        RX_STORE:   r_vidx <= w_vidx_inc;
        MULT_START: r_vidx <= '0;
        TX_LATCH:   r_tx_data <= mem_rdata;
        TX_WAIT:    if (comm_tx_complete) r_vidx <= w_vidx_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr = '0;
    case (r_state)
      RX_STORE: mem_addr = AW'(r_vidx);
      TX_READ:  mem_addr = RES_BASE + AW'(r_vidx);
      default:  mem_addr = '0;
    endcase
  end

  assign comm_op      = (r_state == TX_START) || (r_state == TX_WAIT);
  assign comm_start   = (r_state == RX_START) || (r_state == TX_START);
  assign mem_we       = (r_state == RX_STORE);
  assign mem_wdata    = r_rx_buf;
  assign mult_start   = (r_state == MULT_START);
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);
  assign error        = r_error;
  assign comm_tx_data = r_tx_data;

endmodule
